// File: rtl/fizzbuzz_pkg.sv
// Shared token types and flag classifier for the fizz/buzz token path.
package fizzbuzz_pkg;

  typedef enum logic [1:0] {
    TK_NUM      = 2'd0,
    TK_FIZZ     = 2'd1,
    TK_BUZZ     = 2'd2,
    TK_FIZZBUZZ = 2'd3
  } token_kind_t;

  localparam int unsigned FB_MAX_CYCLES = 100;
  localparam int unsigned FB_IDX_W      = $clog2(FB_MAX_CYCLES);

  typedef struct packed {
    token_kind_t          kind;
    logic [FB_IDX_W-1:0]  index;
  } token_t;

  // fizzbuzz wins even when it disagrees with fizz&buzz
  function automatic token_kind_t classify(input logic fizz, input logic buzz,
                                           input logic fizzbuzz);
    if (fizzbuzz || (fizz && buzz)) return TK_FIZZBUZZ;
    else if (fizz)                  return TK_FIZZ;
    else if (buzz)                  return TK_BUZZ;
    else                            return TK_NUM;
  endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Registered-storage synchronous FIFO with explicit occupancy count.
module fb_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // A pop frees the head slot this edge, so a push into a full FIFO still lands
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fizzbuzz_token_fifo.sv
// Classifies upstream fizz/buzz flags into indexed tokens and buffers them for a sink.
module fizzbuzz_token_fifo
  import fizzbuzz_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 100,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DROP_W     = 8,
  parameter bit          FILTER_NUM = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          fizz,
  input  logic                          buzz,
  input  logic                          fizzbuzz,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [1:0]                    dout_kind,
  output logic [$clog2(MAX_CYCLES)-1:0] dout_index,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          full,
  output logic                          empty,
  output logic [DROP_W-1:0]             drop_count,
  output logic                          flag_err
);

  localparam int unsigned IDX_W = $clog2(MAX_CYCLES);

  typedef struct packed {
    token_kind_t        kind;
    logic [IDX_W-1:0]   index;
  } entry_t;

  token_kind_t      kind;
  logic [IDX_W-1:0] idx;
  logic             push_req;
  logic             pop;
  logic             drop_evt;
  entry_t           wr_entry;
  entry_t           head;

  assign kind       = classify(fizz, buzz, fizzbuzz);
  assign push_req   = in_valid && !(FILTER_NUM && (kind == TK_NUM));
  assign dout_valid = !empty;
  assign pop        = dout_valid && dout_ready;
  assign drop_evt   = push_req && full && !pop;
  assign wr_entry   = '{kind: kind, index: idx};
  assign dout_kind  = head.kind;
  assign dout_index = head.index;

  fb_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Index advances on every valid cycle, including filtered and dropped tokens
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (in_valid) begin
      idx <= (idx == IDX_W'(MAX_CYCLES - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_evt && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_err <= 1'b0;
    end else if (in_valid && (fizzbuzz != (fizz & buzz))) begin
      flag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fizzbuzz_token_fifo.sv
// Directed and random checks of fizzbuzz_token_fifo against a queue-based reference model.
module tb_fizzbuzz_token_fifo;

  localparam int DEPTH = 4;
  localparam int MAXC  = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid, fizz, buzz, fizzbuzz;
  logic       rdy [2];
  logic       dv  [2];
  logic [1:0] dk  [2];
  logic [6:0] di  [2];
  logic [2:0] lv  [2];
  logic       fl  [2];
  logic       em  [2];
  logic [7:0] dc  [2];
  logic       fe  [2];

  int tests = 0;
  int fails = 0;

  // Reference model: one queue of (kind<<8 | index) per instance
  int mq [2][$];
  int obs_idx [2][$];
  int obs_kind [2][$];
  int drops [2];
  int idx;
  bit err;

  initial forever #5 clk = ~clk;

  fizzbuzz_token_fifo #(.MAX_CYCLES(100), .DEPTH(4), .DROP_W(8), .FILTER_NUM(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .fizz(fizz), .buzz(buzz),
    .fizzbuzz(fizzbuzz), .dout_valid(dv[0]), .dout_ready(rdy[0]), .dout_kind(dk[0]),
    .dout_index(di[0]), .level(lv[0]), .full(fl[0]), .empty(em[0]),
    .drop_count(dc[0]), .flag_err(fe[0])
  );

  fizzbuzz_token_fifo #(.MAX_CYCLES(100), .DEPTH(4), .DROP_W(8), .FILTER_NUM(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .fizz(fizz), .buzz(buzz),
    .fizzbuzz(fizzbuzz), .dout_valid(dv[1]), .dout_ready(rdy[1]), .dout_kind(dk[1]),
    .dout_index(di[1]), .level(lv[1]), .full(fl[1]), .empty(em[1]),
    .drop_count(dc[1]), .flag_err(fe[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dout_valid%0d", i), 32'(dv[i]), 32'(mq[i].size() != 0));
      chk($sformatf("level%0d", i),      32'(lv[i]), 32'(mq[i].size()));
      chk($sformatf("full%0d", i),       32'(fl[i]), 32'(mq[i].size() == DEPTH));
      chk($sformatf("empty%0d", i),      32'(em[i]), 32'(mq[i].size() == 0));
      chk($sformatf("drop%0d", i),       32'(dc[i]), 32'(drops[i]));
      chk($sformatf("flag_err%0d", i),   32'(fe[i]), 32'(err));
      if (mq[i].size() != 0) begin
        chk($sformatf("kind%0d", i),  32'(dk[i]), 32'(mq[i][0] >> 8));
        chk($sformatf("index%0d", i), 32'(di[i]), 32'(mq[i][0] & 255));
      end
    end
  endtask

  task automatic model_edge(input bit v, input bit f, input bit b, input bit fb,
                            input bit r0, input bit r1);
    int  kind;
    bit  popk, push, wasfull;
    bit  rr [2];
    kind = (fb || (f && b)) ? 3 : (f ? 1 : (b ? 2 : 0));
    rr[0] = r0;
    rr[1] = r1;
    for (int i = 0; i < 2; i++) begin
      wasfull = (mq[i].size() == DEPTH);
      popk    = (mq[i].size() != 0) && rr[i];
      push    = v && !(i == 1 && kind == 0);
      if (popk) void'(mq[i].pop_front());
      if (push) begin
        if (!wasfull || popk) mq[i].push_back((kind << 8) | idx);
        else if (drops[i] < 255) drops[i]++;
      end
    end
    if (v) begin
      if (fb != (f && b)) err = 1'b1;
      idx = (idx + 1) % MAXC;
    end
  endtask

  task automatic cycle(input bit v, input bit f, input bit b, input bit fb,
                       input bit r0, input bit r1);
    in_valid = v; fizz = f; buzz = b; fizzbuzz = fb;
    rdy[0] = r0; rdy[1] = r1;
    #1;
    check_all();
    for (int i = 0; i < 2; i++) begin
      if (dv[i] && rdy[i]) begin
        obs_idx[i].push_back(32'(di[i]));
        obs_kind[i].push_back(32'(dk[i]));
      end
    end
    model_edge(v, f, b, fb, r0, r1);
    @(posedge clk);
    #1;
  endtask

  task automatic gen_cycle(input bit r0, input bit r1);
    cycle(1'b1, (idx % 3) == 0, (idx % 5) == 0, (idx % 15) == 0, r0, r1);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      obs_idx[i].delete();
      obs_kind[i].delete();
      drops[i] = 0;
    end
    idx = 0;
    err = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; fizz = 1'b0; buzz = 1'b0; fizzbuzz = 1'b0;
    reset = 1'b1;
    model_clear();
    #1;
    check_all();
    chk("rst_kind0",  32'(dk[0]), 32'd0);
    chk("rst_index0", 32'(di[0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int kind_tbl [15] = '{3, 0, 0, 1, 0, 2, 1, 0, 0, 1, 2, 0, 1, 0, 0};
  int filt_tbl [7]  = '{0, 3, 5, 6, 9, 10, 12};
  int ovf_tbl  [5]  = '{0, 1, 2, 3, 6};

  initial begin
    in_valid = 1'b0; fizz = 1'b0; buzz = 1'b0; fizzbuzz = 1'b0;
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    #2;
    do_reset();

    // Upstream sequence, sink always ready
    for (int k = 0; k < 15; k++) gen_cycle(1'b1, 1'b1);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("seq_count", 32'(obs_idx[0].size()), 32'd15);
    for (int k = 0; k < 15; k++) begin
      if (k < obs_idx[0].size()) begin
        chk($sformatf("seq_kind[%0d]", k),  32'(obs_kind[0][k]), 32'(kind_tbl[k]));
        chk($sformatf("seq_index[%0d]", k), 32'(obs_idx[0][k]),  32'(k));
      end
    end
    chk("filt_count", 32'(obs_idx[1].size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      if (k < obs_idx[1].size())
        chk($sformatf("filt_index[%0d]", k), 32'(obs_idx[1][k]), 32'(filt_tbl[k]));
    end

    // Overflow with sink stalled, then push+pop on a full FIFO, then drain
    do_reset();
    for (int k = 0; k < 6; k++) cycle(1, 0, 0, 0, 0, 0);
    chk("ovf_full",  32'(fl[0]), 32'd1);
    chk("ovf_level", 32'(lv[0]), 32'd4);
    chk("ovf_drop",  32'(dc[0]), 32'd2);
    cycle(1, 0, 0, 0, 1, 0);
    chk("pp_level", 32'(lv[0]), 32'd4);
    chk("pp_drop",  32'(dc[0]), 32'd2);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 1, 0);
    chk("drain_empty", 32'(em[0]), 32'd1);
    chk("drain_count", 32'(obs_idx[0].size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < obs_idx[0].size())
        chk($sformatf("drain_index[%0d]", k), 32'(obs_idx[0][k]), 32'(ovf_tbl[k]));
    end

    // Index wrap over 205 valid cycles
    do_reset();
    for (int k = 0; k < 205; k++) gen_cycle(1'b1, 1'b1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("wrap_count", 32'(obs_idx[0].size()), 32'd205);
    if (obs_idx[0].size() == 205) begin
      chk("wrap_99",  32'(obs_idx[0][99]),  32'd99);
      chk("wrap_100", 32'(obs_idx[0][100]), 32'd0);
      chk("wrap_199", 32'(obs_idx[0][199]), 32'd99);
      chk("wrap_200", 32'(obs_idx[0][200]), 32'd0);
      chk("wrap_204", 32'(obs_idx[0][204]), 32'd4);
    end

    // Inconsistent flags: sticky error until reset
    cycle(1, 1, 0, 1, 1, 1);
    chk("err_kind", 32'(dk[0]), 32'd3);
    chk("err_set",  32'(fe[0]), 32'd1);
    for (int k = 0; k < 50; k++) gen_cycle(1'b1, 1'b1);
    chk("err_sticky0", 32'(fe[0]), 32'd1);
    chk("err_sticky1", 32'(fe[1]), 32'd1);
    do_reset();
    chk("err_cleared", 32'(fe[0]), 32'd0);

    // Asynchronous reset with entries held, checked before the next edge
    for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0, 0, 0);
    chk("hold_level0", 32'(lv[0]), 32'd3);
    chk("hold_level1", 32'(lv[1]), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst_level%0d", i), 32'(lv[i]), 32'd0);
      chk($sformatf("arst_empty%0d", i), 32'(em[i]), 32'd1);
      chk($sformatf("arst_valid%0d", i), 32'(dv[i]), 32'd0);
      chk($sformatf("arst_drop%0d", i),  32'(dc[i]), 32'd0);
    end
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bit v, f, b, fb, r0, r1;
      v  = ($urandom_range(0, 3) != 0);
      f  = $urandom_range(0, 1) != 0;
      b  = $urandom_range(0, 1) != 0;
      fb = (f && b) ^ ($urandom_range(0, 15) == 0);
      r0 = ($urandom_range(0, 2) == 0);
      r1 = ($urandom_range(0, 1) == 0);
      cycle(v, f, b, fb, r0, r1);
    end
    cycle(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fizzbuzz_token_fifo.md
Name: fizzbuzz_token_fifo

Overview:
Downstream consumer of the fizz/buzz/fizzbuzz flag generator. Samples the three flags on each valid cycle and classifies them into a 2-bit token kind. Tags each token with a wrapping cycle index and buffers it in a small FIFO. Drains tokens to a printer/UART-style sink over a valid/ready handshake, with overflow accounting and a sticky flag-consistency error.

Parameters:
MAX_CYCLES, 100, index wrap point; must match the upstream generator; index counts 0..MAX_CYCLES-1
DEPTH, 4, FIFO entries; power of 2, >= 2
DROP_W, 8, width of the saturating drop counter
FILTER_NUM, 0, when 1 NUM tokens are not enqueued; their index still advances

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  flags below are meaningful this cycle
fizz  in  1  upstream fizz flag
buzz  in  1  upstream buzz flag
fizzbuzz  in  1  upstream fizzbuzz flag
dout_valid  out  1  head token present (== !empty)
dout_ready  in  1  sink accepts head token this cycle
dout_kind  out  2  head token kind
dout_index  out  $clog2(MAX_CYCLES)  head token cycle index
level  out  $clog2(DEPTH)+1  entries currently held
full  out  1  level == DEPTH
empty  out  1  level == 0
drop_count  out  DROP_W  tokens lost to overflow; saturating
flag_err  out  1  sticky; inconsistent flag combination seen

Behaviour:
- Reset (async, active-high) clears everything immediately: level=0, empty=1, full=0, dout_valid=0, dout_kind=0, dout_index=0, drop_count=0, flag_err=0, index counter=0, read/write pointers=0.
- Reset asserted mid-operation discards all buffered tokens. No output is held across reset.
- Classification (combinational on the inputs):
  - fizzbuzz=1 or (fizz&buzz)=1 -> FIZZBUZZ (3)
  - fizz only -> FIZZ (1)
  - buzz only -> BUZZ (2)
  - none -> NUM (0)
- Consistency check: fizzbuzz != (fizz&buzz) with in_valid=1 sets flag_err at the next edge. It stays set until reset. The token is still classified FIZZBUZZ if fizzbuzz=1.
- Index counter:
  - Advances on every in_valid cycle, whether the token is enqueued, filtered or dropped.
  - Sequence is 0,1,…,MAX_CYCLES-1,0. Wraps via compare to MAX_CYCLES-1, not by natural overflow.
  - The token carries the counter value before the increment.
- Push: push_req = in_valid && !(FILTER_NUM && kind==NUM).
- Pop: pop = dout_valid && dout_ready.
- Push and pop rules:
  - Push while not full: write at wr_ptr; the token is visible at dout no earlier than the next cycle (1-cycle latency, registered storage).
  - Push while full without a same-cycle pop: the token is dropped; drop_count += 1, saturating at 2^DROP_W-1.
  - Push while full with a same-cycle pop: both succeed; level unchanged; no drop.
  - Pop while empty: ignored; dout_ready is don't-care when dout_valid=0.
  - Simultaneous push and pop while not empty and not full: level unchanged; FIFO order preserved.
- dout_kind/dout_index are driven from the head entry combinationally. They are stable while dout_valid=1 and dout_ready=0.
- No bypass path: an empty FIFO never presents the same-cycle input.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level tracks occupancy explicitly (0..DEPTH).

Decomposition:
- Package fizzbuzz_pkg:
  - typedef enum logic[1:0] token_kind_t {TK_NUM, TK_FIZZ, TK_BUZZ, TK_FIZZBUZZ}
  - typedef struct packed token_t {kind, index}
  - the classify function
- Sub-module fb_sync_fifo (parameterised width/depth, async active-high reset, push/pop/full/empty/level). The top holds the classifier, index counter, drop counter and flag_err.

Test Plan:
- Reset, then drive in_valid=1 for 15 cycles with flags from the upstream generator (FIZZ=3, BUZZ=5), dout_ready=1 -> tokens (kind,index) = (3,0),(0,1),(0,2),(1,3),(0,4),(2,5),(1,6)…,(1,12),(0,13),(0,14), each 1 cycle after input.
- dout_ready=0, push 6 tokens with DEPTH=4 -> full=1 after 4th push, drop_count=2, level=4. Drain -> indices 0,1,2,3 in order, then empty=1.
- Full FIFO, in_valid=1 and dout_ready=1 same cycle -> level stays 4, drop_count unchanged, new index appended at tail.
- Run 205 valid cycles with dout_ready=1 -> index sequence wraps 99->0 twice; token at cycle 100 has index 0.
- Drive fizzbuzz=1, fizz=1, buzz=0 once -> token kind 3, flag_err=1 next cycle and still 1 after 50 further clean cycles. Reset -> flag_err=0.
- FILTER_NUM=1, 15 valid cycles -> only indices 0,3,5,6,9,10,12 emitted. Then assert reset mid-drain with 3 entries held -> empty=1, level=0, drop_count=0 immediately, before the next clk edge.
